// File: rtl/data_mem_resp.sv
// Purpose: MEM-stage data memory with fixed wait states, byte/word access and fault reporting.
// Latency: a request first seen in cycle t completes in cycle t+WAIT_CYCLES+2 (MemValid pulse).
// Backpressure: MemBusy stalls the pipeline from request until completion; DONE always returns via IDLE.
//
// Ports:
//   clk, reset       - core clock, asynchronous active-low reset
//   MemReadM         - load request (held while MemBusy=1)
//   MemWriteM        - store request (held while MemBusy=1)
//   MemByteM         - 1 = byte access, 0 = word access
//   ALUResultM[31:0] - byte address
//   WriteDataM[31:0] - store data (byte stores use [7:0])
//   ReadData[31:0]   - registered load result
//   MemBusy          - combinational stall request
//   MemValid         - one-cycle completion pulse
//   MemErr           - one-cycle fault pulse, coincident with MemValid
module data_mem_resp #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_LOG2  = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic        MemByteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadData,
  output logic        MemBusy,
  output logic        MemValid,
  output logic        MemErr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        commit;

  logic [31:0] mem [DEPTH];

  logic                  req;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [1:0]            lane;
  logic [4:0]            lane_bit;
  logic                  misaligned;
  logic                  rw_conflict;
  logic                  do_store;
  logic                  do_load;
  logic [31:0]           cur_word;
  logic [31:0]           load_val;

  // Address bits above the storage window are deliberately ignored (wrap-around).
  logic unused_addr;
  assign unused_addr = ^ALUResultM[31:DEPTH_LOG2+2];

  assign req         = MemReadM | MemWriteM;
  assign word_idx    = ALUResultM[DEPTH_LOG2+1:2];
  assign lane        = ALUResultM[1:0];
  assign lane_bit    = {lane, 3'b000};
  assign misaligned  = !MemByteM && (lane != 2'b00);
  assign rw_conflict = MemReadM & MemWriteM;

  // Store wins over load when both are asserted; misaligned words never touch storage.
  assign do_store = commit & MemWriteM & !misaligned;
  assign do_load  = commit & MemReadM & !MemWriteM;

  assign cur_word = mem[word_idx];

  always_comb begin
    load_val = cur_word;
    if (misaligned) begin
      load_val = 32'h0;
    end else if (MemByteM) begin
      load_val = {24'h0, cur_word[lane_bit +: 8]};
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and stall logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    MemBusy = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          MemBusy = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        MemBusy = 1'b1;
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = 4'(cnt_q - 4'd1);
        end
      end
      // The request still visible in DONE is the one just completed.
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Storage is not reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_store) begin
      if (MemByteM) begin
        mem[word_idx][lane_bit +: 8] <= WriteDataM[7:0];
      end else begin
        mem[word_idx] <= WriteDataM;
      end
    end
  end

  // Completion flags are registered so they are high exactly for the DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ReadData <= 32'h0;
      MemValid <= 1'b0;
      MemErr   <= 1'b0;
    end else begin
      MemValid <= commit;
      MemErr   <= commit & (misaligned | rw_conflict);
      if (do_load) begin
        ReadData <= load_val;
      end
    end
  end

endmodule
